// File: rtl/mvu_rdr_pkg.sv
// Shared types and defaults for the MVU result reader.
package mvu_rdr_pkg;

    localparam int unsigned RDR_RD_LAT_DEF     = 2;
    localparam int unsigned RDR_FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RDR_IDLE  = 2'd0,
        RDR_READ  = 2'd1,
        RDR_DRAIN = 2'd2,
        RDR_DONE  = 2'd3
    } rdr_state_e;

    // Tag riding alongside each outstanding read until its word returns.
    typedef struct packed {
        logic vld;
        logic last;
    } rdr_tag_t;

    // Bits needed to hold a count in 0..depth.
    function automatic int unsigned rdr_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mvu_result_reader_if.sv
// Read-client port toward the MVU plus the valid/ready result stream.
interface mvu_result_reader_if #(
    parameter int unsigned BDBANKA = 15,
    parameter int unsigned BDBANKW = 64
);
    logic               rdc_en;
    logic               rdc_grnt;
    logic [BDBANKA-1:0] rdc_addr;
    logic [BDBANKW-1:0] rdc_word;
    logic               m_valid;
    logic               m_ready;
    logic [BDBANKW-1:0] m_data;
    logic               m_last;

    // Reader side: issues reads, produces the stream.
    modport master (
        output rdc_en, rdc_addr, m_valid, m_data, m_last,
        input  rdc_grnt, rdc_word, m_ready
    );

    // MVU / sink side.
    modport slave (
        input  rdc_en, rdc_addr, m_valid, m_data, m_last,
        output rdc_grnt, rdc_word, m_ready
    );
endinterface

// File: rtl/mvu_rdr_fifo.sv
// First-word-fall-through FIFO with occupancy count; DEPTH must be a power of two.
module mvu_rdr_fifo
    import mvu_rdr_pkg::*;
#(
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = RDR_FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [W-1:0]                  wdata,
    input  logic                          pop,
    output logic [W-1:0]                  rdata,
    output logic                          empty,
    output logic [rdr_cnt_w(DEPTH)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = rdr_cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // Qualified push/pop so a misuse can never corrupt the pointers.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && (cnt != CW'(DEPTH));

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop both take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mvu_result_reader.sv
// Drains an MVU data memory through its read-client port into a valid/ready
// stream, with credit flow control so the output FIFO can never overflow.
// Optional macro MVU_RDR_IRQ_START_EN: a rising edge of mvu_irq_tap while
// idle launches a transfer like start.
module mvu_result_reader
    import mvu_rdr_pkg::*;
#(
    parameter int unsigned BDBANKA    = 15,
    parameter int unsigned BDBANKW    = 64,
    parameter int unsigned RD_LAT     = RDR_RD_LAT_DEF,
    parameter int unsigned FIFO_DEPTH = RDR_FIFO_DEPTH_DEF,
    parameter int unsigned LENW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BDBANKA-1:0]  base_addr,
    input  logic [LENW-1:0]     len,
    output logic                busy,
    output logic                done,
    input  logic                mvu_irq_tap,
    mvu_result_reader_if.master bus
);
    localparam int unsigned CW = rdr_cnt_w(FIFO_DEPTH);
    localparam int unsigned FW = BDBANKW + 1;

    rdr_state_e         state_q;
    rdr_state_e         state_d;
    logic [BDBANKA-1:0] addr_q;
    logic [LENW-1:0]    len_q;
    logic [LENW-1:0]    issue_cnt_q;
    logic [CW-1:0]      inflight_q;
    rdr_tag_t           pend_q [RD_LAT];

    logic               launch;
    logic               rd_en;
    logic               issue;
    logic               last_issue;
    logic               push;
    logic               pop;
    logic [CW-1:0]      credits;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [FW-1:0]      head;
    logic               head_last;

    // Launch decision: explicit start, optionally also an irq rising edge.
`ifdef MVU_RDR_IRQ_START_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= mvu_irq_tap;
        end
    end

    assign launch = (start || (mvu_irq_tap && !irq_q)) && !busy;
`else
    logic unused_irq;
    assign unused_irq = mvu_irq_tap;
    assign launch     = start && !busy;
`endif

    // Credits count FIFO slots not yet claimed by a stored or in-flight word.
    assign credits    = CW'(FIFO_DEPTH) - fifo_count - inflight_q;
    assign rd_en      = (state_q == RDR_READ) && (credits != '0);
    assign issue      = rd_en && bus.rdc_grnt;
    assign last_issue = (issue_cnt_q == len_q - LENW'(1));
    assign push       = pend_q[RD_LAT-1].vld;
    assign pop        = !fifo_empty && bus.m_ready;
    assign head_last  = head[BDBANKW];

    assign bus.rdc_en   = rd_en;
    assign bus.rdc_addr = addr_q;
    assign bus.m_valid  = !fifo_empty;
    assign bus.m_data   = fifo_empty ? '0 : head[BDBANKW-1:0];
    assign bus.m_last   = !fifo_empty && head_last;

    // busy drops in the cycle done pulses, so a new start is accepted in DONE.
    assign busy = (state_q == RDR_READ) || (state_q == RDR_DRAIN);
    assign done = (state_q == RDR_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RDR_IDLE: begin
                if (launch) begin
                    state_d = (len == '0) ? RDR_DONE : RDR_READ;
                end
            end
            RDR_READ: begin
                if (issue && last_issue) begin
                    state_d = RDR_DRAIN;
                end
            end
            RDR_DRAIN: begin
                // The tagged last word leaving means nothing else remains.
                if (pop && head_last && (inflight_q == '0)) begin
                    state_d = RDR_DONE;
                end
            end
            RDR_DONE: begin
                if (launch) begin
                    state_d = (len == '0) ? RDR_DONE : RDR_READ;
                end else begin
                    state_d = RDR_IDLE;
                end
            end
            default: state_d = RDR_IDLE;
        endcase
    end

    // Request address, length, issue count and in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            inflight_q  <= '0;
        end else begin
            if (launch) begin
                addr_q      <= base_addr;
                len_q       <= len;
                issue_cnt_q <= '0;
            end else if (issue) begin
                addr_q      <= addr_q + BDBANKA'(1);
                issue_cnt_q <= issue_cnt_q + LENW'(1);
            end
            inflight_q <= inflight_q + CW'(issue) - CW'(push);
        end
    end

    // Return-tag shift register; the tail marks rdc_word valid this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q[0] <= '{vld: issue, last: issue && last_issue};
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pend_q[i] <= pend_q[i-1];
            end
        end
    end

    // Output buffer holding {last, word}.
    mvu_rdr_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({pend_q[RD_LAT-1].last, bus.rdc_word}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mvu_result_reader.sv
// Directed/randomized bench for mvu_result_reader with a behavioural memory
// and transfer model.
module tb_mvu_result_reader;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        mvu_irq_tap;

    mvu_result_reader_if #(.BDBANKA(15), .BDBANKW(64)) bus ();

    mvu_result_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mvu_irq_tap (mvu_irq_tap),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] salt;
    logic [14:0] iss_addr_q[$];
    int          iss_cyc_q[$];
    logic [63:0] out_q[$];
    logic        out_last_q[$];
    int          first_valid, start_cyc, done_cyc, last_hs, done_cnt, en_cnt, max_out;
    logic        done_busy;
    logic        pv [RD_LAT+1];
    logic [14:0] pa [RD_LAT+1];

    function automatic logic [63:0] memw(input logic [14:0] a);
        return {a, ~a, 2'b10, salt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes handshakes mid-cycle and plays the MVU memory with RD_LAT latency.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.rdc_en) en_cnt++;
            if (bus.rdc_en && bus.rdc_grnt) begin
                iss_addr_q.push_back(bus.rdc_addr);
                iss_cyc_q.push_back(cyc);
            end
            if (bus.m_valid && first_valid < 0) first_valid = cyc;
            if (bus.m_valid && bus.m_ready) begin
                out_q.push_back(bus.m_data);
                out_last_q.push_back(bus.m_last);
                if (bus.m_last) last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (start && !busy) start_cyc = cyc;
            if (int'(iss_addr_q.size()) - int'(out_q.size()) > max_out)
                max_out = int'(iss_addr_q.size()) - int'(out_q.size());
        end
        for (int k = RD_LAT; k > 0; k--) begin
            pv[k] = pv[k-1];
            pa[k] = pa[k-1];
        end
        pv[0] = bus.rdc_en && bus.rdc_grnt;
        pa[0] = bus.rdc_addr;
        bus.rdc_word = pv[RD_LAT] ? memw(pa[RD_LAT]) : {$urandom(), $urandom()};
    end

    task automatic clear_obs();
        iss_addr_q.delete();
        iss_cyc_q.delete();
        out_q.delete();
        out_last_q.delete();
        first_valid = -1;
        start_cyc   = -1;
        done_cyc    = -1;
        last_hs     = -1;
        done_cnt    = 0;
        en_cnt      = 0;
        max_out     = 0;
        done_busy   = 1'bx;
    endtask

    // One transfer: gp = grant percentage, rmode 0=always ready, 1=1-of-3, 2=random.
    task automatic run_xfer(input logic [14:0] b, input logic [15:0] l,
                            input int gp, input int rmode, input bit irq);
        bit got;
        logic [14:0] ea;
        clear_obs();
        @(posedge clk); #1;
        base_addr    = b;
        len          = l;
        start        = !irq;
        mvu_irq_tap  = irq;
        bus.rdc_grnt = ($urandom_range(99) < gp);
        bus.m_ready  = (rmode != 1) || 1'b1;
        got = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (irq) mvu_irq_tap = (n < 2) || (n >= 4 && n < 6);
            bus.rdc_grnt = ($urandom_range(99) < gp);
            case (rmode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (n % 3 == 0);
                default: bus.m_ready = 1'($urandom_range(1));
            endcase
            if (done_cnt != 0 && n >= 6) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("timeout", 64'd0, 64'd1);
        mvu_irq_tap = 1'b0;
        bus.m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_busy", 64'(done_busy), 64'd0);
        chk("n_issued", 64'(iss_addr_q.size()), 64'(l));
        chk("n_out", 64'(out_q.size()), 64'(l));
        for (int i = 0; i < int'(l); i++) begin
            ea = b + 15'(i);
            if (i < int'(iss_addr_q.size())) chk("addr", 64'(iss_addr_q[i]), 64'(ea));
            if (i < int'(out_q.size())) begin
                chk("data", out_q[i], memw(ea));
                chk("last", 64'(out_last_q[i]), 64'(i == int'(l) - 1));
            end
        end
        if (l == 0) begin
            chk("len0_no_rdc_en", 64'(en_cnt), 64'd0);
            chk("len0_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
        end else begin
            chk("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
            chk("credit_bound", 64'(max_out <= int'(DEPTH)), 64'd1);
        end
        if (gp >= 100 && rmode == 0 && l != 0 && !irq && iss_cyc_q.size() == l) begin
            chk("first_issue", 64'(iss_cyc_q[0]), 64'(start_cyc + 1));
            chk("back_to_back", 64'(iss_cyc_q[l-1]), 64'(iss_cyc_q[0] + int'(l) - 1));
            chk("first_valid", 64'(first_valid), 64'(iss_cyc_q[0] + int'(RD_LAT) + 1));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdc_en", 64'(bus.rdc_en), 64'd0);
        chk("rst_rdc_addr", 64'(bus.rdc_addr), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_last", 64'(bus.m_last), 64'd0);
        chk("rst_m_data", bus.m_data, 64'd0);
    endtask

    initial begin
        salt         = $urandom();
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        len          = '0;
        mvu_irq_tap  = 1'b0;
        bus.rdc_grnt = 1'b0;
        bus.m_ready  = 1'b0;
        bus.rdc_word = '0;
        for (int k = 0; k <= RD_LAT; k++) begin
            pv[k] = 1'b0;
            pa[k] = '0;
        end
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        run_xfer(15'h0010, 16'd8, 100, 0, 1'b0);
        run_xfer(15'($urandom()), 16'd16, 100, 1, 1'b0);
        run_xfer(15'($urandom()), 16'd10, 50, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_xfer(15'($urandom()), 16'($urandom_range(20, 1)), $urandom_range(100, 30), 2, 1'b0);
        run_xfer(15'h1234, 16'd0, 100, 0, 1'b0);
        run_xfer(15'h7FFE, 16'd4, 100, 0, 1'b0);

        // Reset three cycles into a transfer, then a clean short one.
        @(posedge clk); #1;
        base_addr    = 15'($urandom());
        len          = 16'd8;
        start        = 1'b1;
        bus.rdc_grnt = 1'b1;
        bus.m_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(15'h0040, 16'd2, 100, 0, 1'b0);

`ifdef MVU_RDR_IRQ_START_EN
        run_xfer(15'h0020, 16'd3, 100, 1, 1'b1);
`else
        clear_obs();
        @(posedge clk); #1;
        base_addr   = 15'h0020;
        len         = 16'd3;
        mvu_irq_tap = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("irq_ignored_busy", 64'(busy), 64'd0);
        chk("irq_ignored_en", 64'(en_cnt), 64'd0);
        mvu_irq_tap = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
